ifu_prefetch_queue: RTL

//  Instruction fetch front end. Generates sequential fetch addresses, runs the read

---
 rtl/ifu_prefetch_queue.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ifu_prefetch_queue.sv
// Instruction fetch front end: issues sequential read requests to memory,
// buffers returned words together with their PCs in a small FIFO and hands
// {IR, PC} pairs to the decode stage. Absorbs halts and branch redirects.
module ifu_prefetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                         clock_in,
    input  logic                         reset_in,
    input  logic                         halt_in,
    input  logic                         redirect_in,
    input  logic [ADDR_WIDTH-1:0]        redirect_addr_in,
    output logic [ADDR_WIDTH-1:0]        mem_addr_out,
    output logic                         mem_read_out,
    input  logic                         mem_valid_in,
    input  logic [DATA_WIDTH-1:0]        mem_data_in,
    output logic                         ins_valid_out,
    output logic [DATA_WIDTH-1:0]        ins_data_out,
    output logic [ADDR_WIDTH-1:0]        ins_pc_out,
    input  logic                         ins_ready_in,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        STALL   = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  fetchPc_q, fetchPc_d;
    logic [ADDR_WIDTH-1:0]  discardPc_q, discardPc_d;
    logic [PTR_W-1:0]       wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]       rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       cntNext;
    logic [DATA_WIDTH-1:0]  dataMem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  pcMem_q   [DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic reqAllowed;

    // Handshake completions; a redirect cancels both the push and the pop.
    assign accept     = (state_q == FETCH) && mem_valid_in;
    assign push       = accept && !redirect_in;
    assign pop        = (count_q != '0) && ins_ready_in && !redirect_in;
    assign cntNext    = count_q + CNT_W'(accept) - CNT_W'(pop);
    // A new request is only issued when a FIFO slot is guaranteed for it.
    assign reqAllowed = (cntNext < DEPTH_C) && !halt_in && !redirect_in;

    // While discarding, the bus must keep showing the abandoned address.
    assign mem_addr_out  = (state_q == DISCARD) ? discardPc_q : fetchPc_q;
    assign mem_read_out  = (state_q != STALL);
    assign ins_valid_out = (count_q != '0);
    assign ins_data_out  = ins_valid_out ? dataMem_q[rdPtr_q] : '0;
    assign ins_pc_out    = ins_valid_out ? pcMem_q[rdPtr_q]   : '0;
    assign occupancy_out = count_q;

    // Request FSM next state: one outstanding request at most.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STALL: begin
                if (reqAllowed) state_d = FETCH;
            end
            FETCH: begin
                if (redirect_in)  state_d = accept ? STALL : DISCARD;
                else if (accept)  state_d = reqAllowed ? FETCH : STALL;
            end
            DISCARD: begin
                if (mem_valid_in) state_d = reqAllowed ? FETCH : STALL;
            end
            default: state_d = STALL;
        endcase
    end

    // Fetch PC and FIFO bookkeeping; a redirect flushes everything.
    always_comb begin
        fetchPc_d   = fetchPc_q;
        discardPc_d = discardPc_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        if (redirect_in) begin
            fetchPc_d = {redirect_addr_in[ADDR_WIDTH-1:2], 2'b00};
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            count_d   = '0;
            if (state_q == FETCH && !accept) discardPc_d = fetchPc_q;
        end else begin
            if (accept) fetchPc_d = fetchPc_q + ADDR_WIDTH'(4);
            if (push)   wrPtr_d   = wrPtr_q + PTR_W'(1);
            if (pop)    rdPtr_d   = rdPtr_q + PTR_W'(1);
            count_d = cntNext;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= STALL;
            fetchPc_q   <= RESET_PC;
            discardPc_q <= RESET_PC;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetchPc_q   <= fetchPc_d;
            discardPc_q <= discardPc_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are masked at the outputs when empty, so no reset.
    always_ff @(posedge clock_in) begin
        if (push) begin
            dataMem_q[wrPtr_q] <= mem_data_in;
            pcMem_q[wrPtr_q]   <= mem_addr_out;
        end
    end

endmodule
